cp0_irq_ctrl: RTL and testbench
===============================

Name: cp0_irq_ctrl

Overview:
- Parametrised coprocessor-0 interrupt sequencer for the 5-stage MIPS pipeline.
- Synchronises N external interrupt lines and holds STATUS, CAUSE and EPC.
- Takes interrupts at the ID stage; drives flush and PC-redirect for interrupt entry and ERET.
- Generates `ir_en`, so no new interrupt is taken while one is being serviced. Serves MFC0/MTC0.

Parameters:
- N_IRQ, 4: number of interrupt lines; legal range 1..8.
- EDGE_MASK, 8'h00: per-line mode; bit=1 means rising-edge latched, bit=0 means level.
- SYNC_STAGES, 2: synchroniser depth on irq_in; legal range 1..3.
- VEC_BASE, 32'h0000_0008: handler base address.
- VECTORED, 0: 1 gives redirect to VEC_BASE + idx*VEC_STRIDE; 0 gives redirect to VEC_BASE.
- VEC_STRIDE, 32'h20: spacing between vectors.

Ports:
- clk, input, 1: main clock.
- rst, input, 1: asynchronous, active-high reset.
- irq_in, input, N_IRQ: raw interrupt lines, asynchronous.
- cp_oper, input, 2: operation of the instruction in ID. 00 none, 01 ERET, 10 MFC0, 11 MTC0.
- cp_addr, input, 5: CP0 register number (inst[15:11]).
- cp_wdata, input, 32: MTC0 data (forwarded rt).
- cp_rdata, output, 32: MFC0 read data; combinational from cp_addr.
- pc_id, input, 32: PC of the instruction in ID.
- id_valid, input, 1: ID holds a real instruction.
- stall_in, input, 1: pipeline is stalling ID (load-use or debug).
- ir_en, output, 1: interrupts may be taken.
- flush, output, 1: reset IF/ID.
- redirect_en, output, 1: override the next PC.
- redirect_pc, output, 32: target PC.
- in_isr, output, 1: a handler is active.

Behaviour:
- Reset values: all outputs 0 except ir_en=0. Internal: IE=0, IM=0, pending=0, EPC=0, synchronisers=0, state=IDLE.
- Registers:
  - STATUS (12): bit0=IE; bits[8+N_IRQ-1:8]=IM.
  - CAUSE (13): bits[8+N_IRQ-1:8]=pending; bits[6:2]=index of the last accepted line.
  - EPC (14).
  - Unused bits and all other addresses read 0.
- Synchroniser: irq_in passes SYNC_STAGES flops to give s. Edge lines additionally keep one flop of s for rise detection.
- Pending:
  - Edge line: set on rise of s; cleared on acceptance of that line; also cleared by MTC0 to CAUSE writing 0 to that bit. MTC0 writing 1 is ignored.
  - Level line: pending = s; no latch; unaffected by MTC0.
  - A set and a clear in the same cycle: set wins.
- Request: req = pending & IM. Winner = lowest set index.
- ir_en = (state==IDLE) & IE.
- Take condition: state==IDLE & ir_en & |req & id_valid & !stall_in. On take:
  - EPC <= pc_id; CAUSE code <= winner index; IE <= 0; the winner's edge pending is cleared; state -> ENTER.
  - The preempted ID instruction's cp_oper is ignored; any MTC0 is suppressed.
- ENTER (1 cycle): flush=1, redirect_en=1. redirect_pc = vector computed from the latched index, 32-bit wrap. Then -> ISR.
- ISR: in_isr=1, ir_en=0.
  - MTC0/MFC0 act normally; a write to IE in ISR takes effect only after LEAVE.
  - ERET with id_valid & !stall_in -> LEAVE.
- LEAVE (1 cycle): flush=1, redirect_en=1, redirect_pc=EPC. IE <= 1 at the end of the cycle; -> IDLE. An interrupt is first takeable the cycle after LEAVE.
- ERET in IDLE (no interrupt taken): also -> LEAVE; MIPS-compatible return to EPC.
- MTC0: writes on a cycle with id_valid & !stall_in & state in {IDLE, ISR}. Writes to read-only or unused fields are dropped.
- MTC0 to EPC in ISR: a following ERET uses the new value.
- Stall: while stall_in=1, no take, no ERET and no MTC0 commit. Pending still accumulates.
- Reset asserted mid-ENTER/LEAVE/ISR: immediate return to reset values; flush/redirect drop asynchronously.
- Outputs flush, redirect_en and redirect_pc are Moore outputs of the FSM state; redirect_pc is a registered value.

Test Plan:
- Reset and config: rst, then MTC0 STATUS=32'h0000_0301 (IE=1, IM=0x3, N_IRQ=4). Then:
  - MFC0 12 returns 32'h0000_0301.
  - MFC0 13 returns 0.
  - ir_en=1.
- Edge entry, VECTORED=1, EDGE_MASK=8'h02, irq_in[1] pulses one cycle, pc_id=32'h40: after SYNC_STAGES+1 cycles, ENTER shows:
  - flush=1, redirect_pc=32'h28.
  - EPC=32'h40, CAUSE[6:2]=1.
  - ir_en=0; CAUSE bit9 cleared.
- Priority and masking: irq_in[0] and irq_in[1] rise together with IM=0x2 → line 1 taken. Then an ERET, and an MTC0 setting IM=0x3 → line 0 is taken the next eligible cycle.
- Nesting blocked: in ISR, raise irq_in[2] with IM bit set → no ENTER. After ERET:
  - LEAVE gives redirect_pc=32'h40.
  - Then IDLE; line 2 is entered on the following eligible cycle.
- Stall and simultaneous events: request pending with stall_in=1 for 3 cycles → no take. stall_in drops while an MTC0 STATUS=0 sits in ID → interrupt taken, write suppressed, EPC=pc_id of that MTC0.
- Async reset mid-ENTER: assert rst → flush=0 and redirect_en=0 immediately; all CP0 registers read 0 after release.

Source files
------------

// File: rtl/cp0_irq_ctrl_if.sv
// Pipeline-side bus of the CP0 interrupt sequencer: the coprocessor
// instruction in ID, its PC and valid/stall qualifiers, plus the
// flush/redirect and status outputs returned to the pipeline.
interface cp0_irq_ctrl_if;
    logic [1:0]  cp_oper;
    logic [4:0]  cp_addr;
    logic [31:0] cp_wdata;
    logic [31:0] cp_rdata;
    logic [31:0] pc_id;
    logic        id_valid;
    logic        stall_in;
    logic        ir_en;
    logic        flush;
    logic        redirect_en;
    logic [31:0] redirect_pc;
    logic        in_isr;

    // Pipeline side: presents the ID instruction, consumes flush/redirect
    modport master (
        output cp_oper, cp_addr, cp_wdata, pc_id, id_valid, stall_in,
        input  cp_rdata, ir_en, flush, redirect_en, redirect_pc, in_isr
    );

    // Controller side
    modport slave (
        input  cp_oper, cp_addr, cp_wdata, pc_id, id_valid, stall_in,
        output cp_rdata, ir_en, flush, redirect_en, redirect_pc, in_isr
    );
endinterface

// File: rtl/cp0_irq_ctrl.sv
// Coprocessor-0 interrupt sequencer for a 5-stage MIPS pipeline.
// Synchronises the interrupt lines, keeps STATUS/CAUSE/EPC, takes an
// interrupt at ID and sequences handler entry and ERET return through
// one-cycle ENTER/LEAVE states that flush IF/ID and redirect the PC.
module cp0_irq_ctrl #(
    parameter int          N_IRQ       = 4,
    parameter logic [7:0]  EDGE_MASK   = 8'h00,
    parameter int          SYNC_STAGES = 2,
    parameter logic [31:0] VEC_BASE    = 32'h0000_0008,
    parameter int          VECTORED    = 0,
    parameter logic [31:0] VEC_STRIDE  = 32'h20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_IRQ-1:0] irq_in,
    cp0_irq_ctrl_if.slave    bus
);

    localparam logic [1:0] OP_ERET  = 2'b01;
    localparam logic [1:0] OP_MTC0  = 2'b11;
    localparam logic [4:0] A_STATUS = 5'd12;
    localparam logic [4:0] A_CAUSE  = 5'd13;
    localparam logic [4:0] A_EPC    = 5'd14;

    typedef enum logic [1:0] {S_IDLE, S_ENTER, S_ISR, S_LEAVE} state_t;

    state_t state_reg, state_next;

    logic [N_IRQ-1:0] sync_reg [SYNC_STAGES];
    logic [N_IRQ-1:0] sync_s;
    logic [N_IRQ-1:0] pending;
    logic [N_IRQ-1:0] req;
    logic [4:0]       win_idx;

    logic             ie_reg;
    logic             ie_defer_reg;   // IE value restored when LEAVE completes
    logic [N_IRQ-1:0] im_reg;
    logic [4:0]       code_reg;
    logic [31:0]      epc_reg;
    logic [31:0]      redirect_pc_reg;

    logic        is_idle;
    logic        fire;
    logic        take;
    logic        eret;
    logic        mtc;
    logic        mtc_cause;
    logic [31:0] vec_pc;
    logic [31:0] rdata;

    // Synchroniser chain on the raw asynchronous lines
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_reg[k] <= '0;
        end else begin
            sync_reg[0] <= irq_in;
            for (int k = 1; k < SYNC_STAGES; k++) sync_reg[k] <= sync_reg[k-1];
        end
    end

    assign sync_s = sync_reg[SYNC_STAGES-1];

    // Per-line pending: edge lines latch rises, level lines follow the synchronised input
    genvar gi;
    generate
        for (gi = 0; gi < N_IRQ; gi++) begin : g_line
            if (EDGE_MASK[gi]) begin : g_edge
                logic s_prev_reg;
                logic pend_reg;
                logic set_w;
                logic clr_w;

                assign set_w = sync_s[gi] & ~s_prev_reg;
                assign clr_w = (take && (win_idx == 5'(gi))) ||
                               (mtc_cause && !bus.cp_wdata[8+gi]);

                // Rise detector and latch; a new rise beats a same-cycle clear
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        s_prev_reg <= 1'b0;
                        pend_reg   <= 1'b0;
                    end else begin
                        s_prev_reg <= sync_s[gi];
                        pend_reg   <= (pend_reg & ~clr_w) | set_w;
                    end
                end

                assign pending[gi] = pend_reg;
            end else begin : g_level
                assign pending[gi] = sync_s[gi];
            end
        end
    endgenerate

    assign req = pending & im_reg;

    // Lowest-numbered requesting line wins
    always_comb begin
        win_idx = '0;
        for (int k = N_IRQ - 1; k >= 0; k--) begin
            if (req[k]) win_idx = 5'(k);
        end
    end

    assign vec_pc = (VECTORED != 0) ? (VEC_BASE + 32'(win_idx) * VEC_STRIDE) : VEC_BASE;

    // Instruction qualifiers; a taken interrupt pre-empts whatever sits in ID
    assign is_idle   = (state_reg == S_IDLE);
    assign fire      = bus.id_valid & ~bus.stall_in;
    assign take      = is_idle & ie_reg & (|req) & fire;
    assign eret      = ~take & fire & (bus.cp_oper == OP_ERET) &
                       (is_idle | (state_reg == S_ISR));
    assign mtc       = ~take & fire & (bus.cp_oper == OP_MTC0) &
                       (is_idle | (state_reg == S_ISR));
    assign mtc_cause = mtc & (bus.cp_addr == A_CAUSE);

    // Sequencer next state
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (take) state_next = S_ENTER;
                     else if (eret) state_next = S_LEAVE;
            S_ENTER: state_next = S_ISR;
            S_ISR:   if (eret) state_next = S_LEAVE;
            S_LEAVE: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // State register and CP0 register file updates
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= S_IDLE;
            ie_reg          <= 1'b0;
            ie_defer_reg    <= 1'b0;
            im_reg          <= '0;
            code_reg        <= '0;
            epc_reg         <= '0;
            redirect_pc_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (take) begin
                epc_reg         <= bus.pc_id;
                code_reg        <= win_idx;
                ie_reg          <= 1'b0;
                ie_defer_reg    <= 1'b1;
                redirect_pc_reg <= vec_pc;
            end else if (eret) begin
                redirect_pc_reg <= epc_reg;
                if (is_idle) ie_defer_reg <= 1'b1;
            end
            if (mtc && (bus.cp_addr == A_STATUS)) begin
                im_reg <= bus.cp_wdata[8 +: N_IRQ];
                // Inside a handler the IE write is held until the return completes
                if (is_idle) ie_reg <= bus.cp_wdata[0];
                else         ie_defer_reg <= bus.cp_wdata[0];
            end
            if (mtc && (bus.cp_addr == A_EPC)) epc_reg <= bus.cp_wdata;
            if (state_reg == S_LEAVE) ie_reg <= ie_defer_reg;
        end
    end

    // MFC0 read mux; unused fields and addresses read as zero
    always_comb begin
        rdata = '0;
        case (bus.cp_addr)
            A_STATUS: begin
                rdata[0]          = ie_reg;
                rdata[8 +: N_IRQ] = im_reg;
            end
            A_CAUSE: begin
                rdata[8 +: N_IRQ] = pending;
                rdata[6:2]        = code_reg;
            end
            A_EPC:   rdata = epc_reg;
            default: rdata = '0;
        endcase
    end

    assign bus.cp_rdata    = rdata;
    assign bus.ir_en       = is_idle & ie_reg;
    assign bus.flush       = (state_reg == S_ENTER) | (state_reg == S_LEAVE);
    assign bus.redirect_en = (state_reg == S_ENTER) | (state_reg == S_LEAVE);
    assign bus.redirect_pc = bus.redirect_en ? redirect_pc_reg : 32'h0;
    assign bus.in_isr      = (state_reg == S_ISR);

endmodule

// File: tb/tb_cp0_irq_ctrl.sv
// Bench for cp0_irq_ctrl (N_IRQ=4, line 1 edge, others level, vectored).
// A behavioural model tracks the CP0 registers and handler phase from
// the architectural rules; one process compares every output each cycle
// and directed scenarios pin literal values.
module tb_cp0_irq_ctrl;

    localparam int          N    = 4;
    localparam int          SYNC = 2;
    localparam logic [7:0]  EDGE = 8'h02;
    localparam bit   [3:0]  EDGE4 = 4'b0010;
    localparam logic [31:0] BASE = 32'h8;
    localparam logic [31:0] STRIDE = 32'h20;

    localparam logic [1:0] OP_NONE = 2'd0, OP_ERET = 2'd1, OP_MFC0 = 2'd2, OP_MTC0 = 2'd3;
    localparam int P_IDLE = 0, P_ENTER = 1, P_ISR = 2, P_LEAVE = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] irq = '0;

    cp0_irq_ctrl_if bus();

    cp0_irq_ctrl #(
        .N_IRQ(N), .EDGE_MASK(EDGE), .SYNC_STAGES(SYNC),
        .VEC_BASE(BASE), .VECTORED(1), .VEC_STRIDE(STRIDE)
    ) dut (
        .clk(clk), .rst(rst), .irq_in(irq), .bus(bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h t=%0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int        m_phase;
    bit        m_ie, m_ie_after;
    bit [3:0]  m_im, m_edge_pend, m_prev_s;
    bit [4:0]  m_code;
    bit [31:0] m_epc;
    bit [3:0]  hist[$];   // hist[k] = irq sampled k+1 edges ago

    function automatic bit [3:0] m_pending();
        bit [3:0] s;
        s = hist[SYNC-1];
        return (m_edge_pend & EDGE4) | (s & ~EDGE4);
    endfunction

    function automatic logic [31:0] m_rdata(input logic [4:0] a);
        case (a)
            5'd12:   return {20'h0, m_im, 7'h0, m_ie};
            5'd13:   return {20'h0, m_pending(), 1'b0, m_code, 2'b00};
            5'd14:   return m_epc;
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin : model
        bit [3:0] s, req, rise, clr;
        int win;
        bit fire, take, eret, mtc, active;
        if (rst) begin
            m_phase = P_IDLE; m_ie = 0; m_ie_after = 0; m_im = 0;
            m_edge_pend = 0; m_prev_s = 0; m_code = 0; m_epc = 0;
            hist.delete();
            for (int i = 0; i < SYNC; i++) hist.push_back(4'h0);
        end else begin
            s   = hist[SYNC-1];
            req = m_pending() & m_im;
            win = -1;
            for (int i = 0; i < N; i++) if (req[i] && win < 0) win = i;
            fire   = bus.id_valid && !bus.stall_in;
            active = (m_phase == P_IDLE) || (m_phase == P_ISR);
            take   = (m_phase == P_IDLE) && m_ie && (win >= 0) && fire;
            eret   = !take && fire && active && bus.cp_oper == OP_ERET;
            mtc    = !take && fire && active && bus.cp_oper == OP_MTC0;
            rise   = s & ~m_prev_s & EDGE4;
            clr    = 0;
            if (take) clr[win] = 1'b1;
            if (mtc && bus.cp_addr == 5'd13) clr = clr | ~bus.cp_wdata[11:8];
            m_edge_pend = ((m_edge_pend & ~clr) | rise) & EDGE4;
            if (mtc && bus.cp_addr == 5'd12) begin
                m_im = bus.cp_wdata[11:8];
                if (m_phase == P_IDLE) m_ie = bus.cp_wdata[0];
                else m_ie_after = bus.cp_wdata[0];
            end
            if (mtc && bus.cp_addr == 5'd14) m_epc = bus.cp_wdata;
            case (m_phase)
                P_IDLE: begin
                    if (take) begin
                        m_epc = bus.pc_id; m_code = 5'(win); m_ie = 0; m_ie_after = 1;
                        m_phase = P_ENTER;
                    end else if (eret) begin
                        m_ie_after = 1; m_phase = P_LEAVE;
                    end
                end
                P_ENTER: m_phase = P_ISR;
                P_ISR:   if (eret) m_phase = P_LEAVE;
                default: begin m_ie = m_ie_after; m_phase = P_IDLE; end
            endcase
            m_prev_s = s;
            hist.push_front(irq);
            void'(hist.pop_back());
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                check("ir_en", bus.ir_en, (m_phase == P_IDLE) && m_ie);
                check("flush", bus.flush, (m_phase == P_ENTER) || (m_phase == P_LEAVE));
                check("redirect_en", bus.redirect_en, (m_phase == P_ENTER) || (m_phase == P_LEAVE));
                check("in_isr", bus.in_isr, m_phase == P_ISR);
                check("redirect_pc", bus.redirect_pc,
                      (m_phase == P_ENTER) ? BASE + 32'(m_code) * STRIDE :
                      (m_phase == P_LEAVE) ? m_epc : 32'h0);
                check("cp_rdata", bus.cp_rdata, m_rdata(bus.cp_addr));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic [1:0] op, input logic [4:0] a, input logic [31:0] wd,
                         input logic [31:0] pc, input logic v, input logic st);
        bus.cp_oper = op; bus.cp_addr = a; bus.cp_wdata = wd;
        bus.pc_id = pc; bus.id_valid = v; bus.stall_in = st;
    endtask

    task automatic rd(input string name, input logic [4:0] a, input logic [31:0] exp);
        bus.cp_oper = OP_MFC0;
        bus.cp_addr = a;
        #1;
        check(name, bus.cp_rdata, exp);
    endtask

    task automatic wait_flush(input string name);
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.flush === 1'b1) return;
        end
        checks++;
        errors++;
        $display("FAIL %s got=no_flush expected=flush within 12 cycles", name);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout got=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        drive(OP_NONE, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0);
        rst = 1'b1;
        repeat (3) tick();
        bus.cp_addr = 5'd12;
        #1;
        check("rst_flush", bus.flush, 0);
        check("rst_ir_en", bus.ir_en, 0);
        check("rst_redirect_en", bus.redirect_en, 0);
        check("rst_status", bus.cp_rdata, 0);
        rst = 1'b0;
        tick();

        // configuration: IE=1, IM=0x3
        drive(OP_MTC0, 5'd12, 32'h0000_0301, 32'h0, 1'b1, 1'b0);
        tick();
        drive(OP_NONE, 5'd0, 32'h0, 32'h40, 1'b1, 1'b0);
        rd("cfg_status", 5'd12, 32'h0000_0301);
        rd("cfg_cause", 5'd13, 32'h0);
        check("cfg_ir_en", bus.ir_en, 1);

        // edge entry on line 1
        drive(OP_NONE, 5'd0, 32'h0, 32'h40, 1'b1, 1'b0);
        irq = 4'b0010;
        tick();
        irq = 4'b0000;
        wait_flush("edge_enter");
        check("edge_redirect_pc", bus.redirect_pc, 32'h28);
        check("edge_ir_en", bus.ir_en, 0);
        rd("edge_epc", 5'd14, 32'h40);
        rd("edge_cause", 5'd13, 32'h0000_0004);
        drive(OP_NONE, 5'd0, 32'h0, 32'h44, 1'b1, 1'b0);
        tick();
        check("edge_in_isr", bus.in_isr, 1);

        // nesting blocked: unmask line 2 inside the handler and raise it
        drive(OP_MTC0, 5'd12, 32'h0000_0701, 32'h48, 1'b1, 1'b0);
        tick();
        drive(OP_NONE, 5'd0, 32'h0, 32'h4c, 1'b1, 1'b0);
        irq = 4'b0100;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("nest_no_flush", bus.flush, 0);
        end
        rd("nest_cause", 5'd13, 32'h0000_0404);
        drive(OP_ERET, 5'd0, 32'h0, 32'h50, 1'b1, 1'b0);
        tick();
        check("leave_flush", bus.flush, 1);
        check("leave_redirect_pc", bus.redirect_pc, 32'h40);
        drive(OP_NONE, 5'd0, 32'h0, 32'h60, 1'b1, 1'b0);
        tick();
        check("after_leave_ir_en", bus.ir_en, 1);
        tick();
        check("line2_enter", bus.flush, 1);
        check("line2_redirect_pc", bus.redirect_pc, 32'h48);
        irq = 4'b0000;
        tick();
        drive(OP_ERET, 5'd0, 32'h0, 32'h64, 1'b1, 1'b0);
        tick();
        drive(OP_NONE, 5'd0, 32'h0, 32'h100, 1'b1, 1'b0);
        tick();

        // priority and masking: lines 0 and 1 together with IM=0x2
        drive(OP_MTC0, 5'd12, 32'h0000_0201, 32'h100, 1'b1, 1'b0);
        tick();
        drive(OP_NONE, 5'd0, 32'h0, 32'h100, 1'b1, 1'b0);
        irq = 4'b0011;
        tick();
        irq = 4'b0001;
        wait_flush("prio_enter");
        check("prio_redirect_pc", bus.redirect_pc, 32'h28);
        rd("prio_cause", 5'd13, 32'h0000_0104);
        tick();
        drive(OP_ERET, 5'd0, 32'h0, 32'h104, 1'b1, 1'b0);
        tick();
        drive(OP_NONE, 5'd0, 32'h0, 32'h108, 1'b1, 1'b0);
        tick();
        check("prio_masked_idle", bus.ir_en, 1);
        drive(OP_MTC0, 5'd12, 32'h0000_0301, 32'h10c, 1'b1, 1'b0);
        tick();
        check("prio_no_take_on_mtc", bus.flush, 0);
        drive(OP_NONE, 5'd0, 32'h0, 32'h110, 1'b1, 1'b0);
        tick();
        check("line0_enter", bus.flush, 1);
        check("line0_redirect_pc", bus.redirect_pc, 32'h08);
        irq = 4'b0000;
        tick();
        drive(OP_ERET, 5'd0, 32'h0, 32'h114, 1'b1, 1'b0);
        tick();
        drive(OP_NONE, 5'd0, 32'h0, 32'h118, 1'b1, 1'b0);
        tick();

        // stall holds off a pending request; MTC0 in ID is pre-empted
        drive(OP_MTC0, 5'd12, 32'h0000_0000, 32'h200, 1'b1, 1'b1);
        irq = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_no_flush", bus.flush, 0);
        end
        check("stall_ir_en", bus.ir_en, 1);
        bus.stall_in = 1'b0;
        tick();
        check("stall_take", bus.flush, 1);
        check("stall_redirect_pc", bus.redirect_pc, 32'h08);
        rd("stall_epc", 5'd14, 32'h200);
        rd("stall_status", 5'd12, 32'h0000_0300);

        // asynchronous reset in the middle of ENTER
        rst = 1'b1;
        #1;
        check("arst_flush", bus.flush, 0);
        check("arst_redirect_en", bus.redirect_en, 0);
        irq = 4'b0000;
        tick();
        rst = 1'b0;
        drive(OP_NONE, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0);
        rd("arst_status", 5'd12, 32'h0);
        rd("arst_cause", 5'd13, 32'h0);
        rd("arst_epc", 5'd14, 32'h0);
        check("arst_ir_en", bus.ir_en, 0);
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
